// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, RX state encoding,
// divisor limit and the parity-check helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam int unsigned DIV_MIN = 32'd4;

  typedef enum logic [2:0] {
    RX_IDLE   = ST_IDLE,
    RX_START  = ST_START,
    RX_DATA   = ST_DATA,
    RX_PARITY = ST_PARITY,
    RX_STOP   = ST_STOP,
    RX_BREAK  = ST_BREAK
  } rx_state_t;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Mode 11 falls into the default arm and never reports a parity error.
  function automatic logic parity_err(input logic data_xor, input logic sample,
                                      input logic [1:0] mode);
    logic err;
    case (mode)
      PAR_EVEN: err = data_xor ^ sample;
      PAR_ODD:  err = ~(data_xor ^ sample);
      default:  err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with combinational head, occupancy count and
// sticky overrun raised when a push is dropped on a full buffer.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clr_ovr,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       not_empty,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_s;
  logic             ovr_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             drop_s;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign pop_ok_s  = pop & ~empty_s;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign push_ok_s = push & (~full_s | pop_ok_s);
  assign drop_s    = push & full_s & ~pop_ok_s;

  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign not_empty = ~empty_s;
  assign overrun   = ovr_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_s = count_r + (AW+1)'(1);
      2'b01:   count_s = count_r - (AW+1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Storage, pointers, count and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovr_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_s;
      if (drop_s) begin
        ovr_r <= 1'b1;
      end else if (clr_ovr) begin
        ovr_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: synchronised RXD, glitch-rejecting start detect, parity and
// framing checks, characters queued in a small FIFO with sticky overrun.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RXD,
  input  logic [DIV_W-1:0]              div,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  input  logic                          clr_ovr,
  output logic                          busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 rxs_r;
  rx_state_t            state_r,    state_s;
  logic [DIV_W-1:0]     cnt_r,      cnt_s;
  logic [BW-1:0]        bit_idx_r,  bit_idx_s;
  logic [DATA_BITS-1:0] shreg_r,    shreg_s;
  logic                 perr_r,     perr_s;
  logic                 ferr_r,     ferr_s;
  logic [DIV_W-1:0]     div_r,      div_s;
  logic [1:0]           par_r,      par_s;
  logic                 stop2_r,    stop2_s;
  logic                 stop_idx_r, stop_idx_s;
  logic                 push_s;
  logic [EW-1:0]        push_data_s;
  logic [EW-1:0]        head_s;
  logic [DIV_W-1:0]     half_s;
  logic [DIV_W-1:0]     last_s;

  assign half_s = div_r >> 1;
  assign last_s = div_r - DIV_W'(1);

  // Next-state and datapath update for the receive FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + DIV_W'(1);
    bit_idx_s   = bit_idx_r;
    shreg_s     = shreg_r;
    perr_s      = perr_r;
    ferr_s      = ferr_r;
    div_s       = div_r;
    par_s       = par_r;
    stop2_s     = stop2_r;
    stop_idx_s  = stop_idx_r;
    push_s      = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_s = {DIV_W{1'b0}};
        if (!rxs_r) begin
          div_s      = div;
          par_s      = par_mode;
          stop2_s    = stop2;
          perr_s     = 1'b0;
          ferr_s     = 1'b0;
          stop_idx_s = 1'b0;
          state_s    = RX_START;
        end else begin
          state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == half_s) begin
          cnt_s     = {DIV_W{1'b0}};
          bit_idx_s = {BW{1'b0}};
          state_s   = rxs_r ? RX_IDLE : RX_DATA;
        end else begin
          state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_r == last_s) begin
          cnt_s     = {DIV_W{1'b0}};
          shreg_s   = {rxs_r, shreg_r[DATA_BITS-1:1]};
          bit_idx_s = bit_idx_r + BW'(1);
          if (bit_idx_r == LAST_BIT) begin
            state_s = par_enabled(par_r) ? RX_PARITY : RX_STOP;
          end else begin
            state_s = RX_DATA;
          end
        end else begin
          state_s = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (cnt_r == last_s) begin
          cnt_s   = {DIV_W{1'b0}};
          perr_s  = parity_err(^shreg_r, rxs_r, par_r);
          state_s = RX_STOP;
        end else begin
          state_s = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (cnt_r == last_s) begin
          cnt_s  = {DIV_W{1'b0}};
          ferr_s = ferr_r | ~rxs_r;
          if (stop2_r && !stop_idx_r) begin
            stop_idx_s = 1'b1;
            state_s    = RX_STOP;
          end else begin
            push_s  = 1'b1;
            state_s = rxs_r ? RX_IDLE : RX_BREAK;
          end
        end else begin
          state_s = RX_STOP;
        end
      end
      RX_BREAK: begin
        // Held-low line: one ferr character already pushed, wait for release.
        cnt_s   = {DIV_W{1'b0}};
        state_s = rxs_r ? RX_IDLE : RX_BREAK;
      end
      default: begin
        cnt_s   = {DIV_W{1'b0}};
        state_s = RX_IDLE;
      end
    endcase
  end

  assign push_data_s = {perr_r, ferr_s, shreg_r};

  // RXD synchroniser and FSM/datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b1;
      rxs_r      <= 1'b1;
      state_r    <= RX_IDLE;
      cnt_r      <= {DIV_W{1'b0}};
      bit_idx_r  <= {BW{1'b0}};
      shreg_r    <= {DATA_BITS{1'b0}};
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      div_r      <= {DIV_W{1'b0}};
      par_r      <= PAR_NONE;
      stop2_r    <= 1'b0;
      stop_idx_r <= 1'b0;
    end else begin
      sync1_r    <= RXD;
      rxs_r      <= sync1_r;
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_idx_r  <= bit_idx_s;
      shreg_r    <= shreg_s;
      perr_r     <= perr_s;
      ferr_r     <= ferr_s;
      div_r      <= div_s;
      par_r      <= par_s;
      stop2_r    <= stop2_s;
      stop_idx_r <= stop_idx_s;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rx_ready),
    .clr_ovr   (clr_ovr),
    .head      (head_s),
    .count     (rx_count),
    .not_empty (rx_valid),
    .overrun   (overrun)
  );

  assign rx_data = head_s[DATA_BITS-1:0];
  assign rx_ferr = head_s[DATA_BITS];
  assign rx_perr = head_s[DATA_BITS+1];
  assign busy    = (state_r != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: frames are serialised onto RXD, expected
// characters queued at send time and compared as the FIFO is drained.
module tb_uart_rx_ext;

  localparam int DATA_BITS  = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV        = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 RXD;
  logic [DIV_W-1:0]     div;
  logic [1:0]           par_mode;
  logic                 stop2;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_perr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [CW-1:0]        rx_count;
  logic                 overrun;
  logic                 clr_ovr;
  logic                 busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  int         lat_n;
  bit         lat_seen;

  always #5 clk = ~clk;

  uart_rx_ext #(
    .DATA_BITS  (DATA_BITS),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RXD      (RXD),
    .div      (div),
    .par_mode (par_mode),
    .stop2    (stop2),
    .rx_data  (rx_data),
    .rx_perr  (rx_perr),
    .rx_ferr  (rx_ferr),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_count (rx_count),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RXD = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Expected {perr, ferr, data} derived from the bits put on the wire.
  task automatic send_char(input logic [7:0] d, input bit has_par, input logic pbit,
                           input int nstop, input logic [1:0] stops,
                           input bit exp_push, input bit hold_low);
    logic perr;
    logic ferr;
    perr = 1'b0;
    if (has_par) perr = (par_mode == 2'b01) ? (^d ^ pbit) : ~(^d ^ pbit);
    ferr = (nstop == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
    if (exp_push) exp_q.push_back({perr, ferr, d});
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    for (int i = 0; i < nstop; i++) drive_bit(stops[i]);
    if (!hold_low) begin
      RXD = 1'b1;
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_count"}, 32'(rx_count), 32'd0);
    check({tag, "_ovr"},   32'(overrun),  32'd0);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_head"},  32'({rx_perr, rx_ferr, rx_data}), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every accepted character must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_char", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rx_char", 32'({rx_perr, rx_ferr, rx_data}), 32'(mon_exp));
      end
    end
  end

  initial begin
    rst = 1'b1; RXD = 1'b1; div = DIV_W'(DIV); par_mode = 2'b00; stop2 = 1'b0;
    rx_ready = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    rx_ready = 1'b1;

    // 8N1 0xA5 with latency and occupancy check.
    lat_n = 0; lat_seen = 1'b0;
    fork
      send_char(8'hA5, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        while (!lat_seen && lat_n < 400) begin
          @(posedge clk);
          lat_n++;
          @(negedge clk);
          if (rx_valid) begin
            lat_seen = 1'b1;
            check("first_count", 32'(rx_count), 32'd1);
          end
        end
        check("latency", 32'(lat_n), 32'(4 + DIV / 2 + 9 * DIV));
      end
    join
    wait_drain("drain_a5");

    // Parity modes.
    par_mode = 2'b01;
    send_char(8'h07, 1'b1, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    send_char(8'h07, 1'b1, 1'b1, 1, 2'b11, 1'b1, 1'b0);
    par_mode = 2'b10;
    send_char(8'h07, 1'b1, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    send_char(8'hE1, 1'b1, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    par_mode = 2'b11;
    send_char(8'h5A, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    par_mode = 2'b00;
    wait_drain("drain_par");

    // Two stop bits: clean, then bad second stop.
    stop2 = 1'b1;
    send_char(8'hC3, 1'b0, 1'b0, 2, 2'b11, 1'b1, 1'b0);
    send_char(8'h96, 1'b0, 1'b0, 2, 2'b01, 1'b1, 1'b0);
    stop2 = 1'b0;
    wait_drain("drain_stop2");

    // Start-bit glitch shorter than half a bit.
    RXD = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    RXD = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_count", 32'(rx_count), 32'd0);

    // Break: bad stop then line held low, one ferr character only.
    send_char(8'h00, 1'b0, 1'b0, 1, 2'b00, 1'b1, 1'b1);
    repeat (10 * DIV) @(posedge clk);
    #1;
    check("break_busy", 32'(busy), 32'd1);
    check("break_count", 32'(rx_count), 32'd0);
    RXD = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    check("break_exit", 32'(busy), 32'd0);
    send_char(8'h3C, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_break");

    // Overrun: fifth character dropped.
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_char(8'(i), 1'b0, 1'b0, 1, 2'b11, (i <= FIFO_DEPTH), 1'b0);
    end
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_count", 32'(rx_count), 32'(FIFO_DEPTH));
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    rx_ready = 1'b1;
    wait_drain("drain_ovr");
    check("ovr_empty", 32'(rx_count), 32'd0);

    // Full FIFO with a pop coinciding with the push of 0x55.
    rx_ready = 1'b0;
    send_char(8'h11, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    send_char(8'h22, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    send_char(8'h33, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    send_char(8'h44, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    fork
      send_char(8'h55, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
      begin
        @(posedge clk); #1;
        repeat (3 + DIV / 2 + 9 * DIV) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check("popush_count", 32'(rx_count), 32'(FIFO_DEPTH));
        check("popush_ovr", 32'(overrun), 32'd0);
      end
    join
    rx_ready = 1'b1;
    wait_drain("drain_popush");

    // Reset mid-DATA with a character waiting in the FIFO.
    rx_ready = 1'b0;
    send_char(8'h99, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    RXD = 1'b0;
    repeat (DIV + 3 * DIV) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    RXD = 1'b1;
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    check_reset_state("postrst");
    rx_ready = 1'b1;
    send_char(8'h81, 1'b0, 1'b0, 1, 2'b11, 1'b1, 1'b0);
    wait_drain("drain_81");
    check("final_count", 32'(rx_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
